// File: rtl/wormhole_oc_arbiter_if.sv
// rtl/wormhole_oc_arbiter_if.sv - output-port allocator signal bundle
interface wormhole_oc_arbiter_if #(
    parameter int IN_N      = 5,
    parameter int BUF_DEPTH = 4
);
    localparam int CRED_W = $clog2(BUF_DEPTH + 1);

    logic [IN_N-1:0]   req_i;
    logic [IN_N-1:0]   flit_vld_i;
    logic [IN_N-1:0]   flit_is_tail_i;
    logic              credit_ret_i;
    logic [IN_N-1:0]   grant_o;
    logic [IN_N-1:0]   ic_pop_o;
    logic              oc_vld_o;
    logic [CRED_W-1:0] credits_o;
    logic              credit_err_o;

    modport master (
        input  req_i, flit_vld_i, flit_is_tail_i, credit_ret_i,
        output grant_o, ic_pop_o, oc_vld_o, credits_o, credit_err_o
    );

    modport slave (
        output req_i, flit_vld_i, flit_is_tail_i, credit_ret_i,
        input  grant_o, ic_pop_o, oc_vld_o, credits_o, credit_err_o
    );
endinterface

// File: rtl/wormhole_oc_arbiter.sv
// rtl/wormhole_oc_arbiter.sv - round-robin wormhole allocator with downstream credits
module wormhole_oc_arbiter #(
    parameter int IN_N      = 5,
    parameter int BUF_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    wormhole_oc_arbiter_if.master bus
);
    localparam int CRED_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W  = (IN_N > 1) ? $clog2(IN_N) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [IN_N-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CRED_W-1:0] credits_q, credits_d;
    logic              err_q, err_d;

    logic              owner_vld;
    logic              owner_tail;
    logic              xfer;
    logic              found;
    logic [PTR_W-1:0]  winner;

    always_comb begin
        owner_vld  = |(grant_q & bus.flit_vld_i);
        owner_tail = |(grant_q & bus.flit_is_tail_i);
        xfer       = (state_q == LOCKED) && owner_vld && (credits_q != '0);
    end

    // Search starts at ptr and wraps, so the last winner has lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < IN_N; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= IN_N) begin
                idx = idx - IN_N;
            end
            if (!found && bus.req_i[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (found) begin
                    state_d = LOCKED;
                    grant_d = IN_N'(1) << winner;
                    ptr_d   = (winner == PTR_W'(IN_N - 1)) ? '0 : winner + PTR_W'(1);
                end
            end
            LOCKED: begin
                if (xfer && owner_tail) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // A return with a transfer in the same cycle cancels out; a surplus return saturates.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        if (xfer && !bus.credit_ret_i) begin
            credits_d = credits_q - CRED_W'(1);
        end else if (!xfer && bus.credit_ret_i) begin
            if (credits_q == CRED_W'(BUF_DEPTH)) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + CRED_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            credits_q <= CRED_W'(BUF_DEPTH);
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign bus.grant_o      = grant_q;
    assign bus.ic_pop_o     = grant_q & {IN_N{xfer}};
    assign bus.oc_vld_o     = xfer;
    assign bus.credits_o    = credits_q;
    assign bus.credit_err_o = err_q;
endmodule

// File: tb/tb_wormhole_oc_arbiter.sv
// tb/tb_wormhole_oc_arbiter.sv - directed self-checking bench for wormhole_oc_arbiter
module tb_wormhole_oc_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    wormhole_oc_arbiter_if #(.IN_N(5), .BUF_DEPTH(4)) bus ();

    wormhole_oc_arbiter #(.IN_N(5), .BUF_DEPTH(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [4:0] g, input logic [4:0] pop,
                              input logic oc, input logic [2:0] cred);
        #4;
        chk({tag, ".grant"},   32'(bus.grant_o),   32'(g));
        chk({tag, ".pop"},     32'(bus.ic_pop_o),  32'(pop));
        chk({tag, ".oc_vld"},  32'(bus.oc_vld_o),  32'(oc));
        chk({tag, ".credits"}, 32'(bus.credits_o), 32'(cred));
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.req_i          = '0;
        bus.flit_vld_i     = '0;
        bus.flit_is_tail_i = '0;
        bus.credit_ret_i   = 1'b0;
        nxt();
        rst = 1'b0;
    endtask

    logic [4:0] rr_seq [4];

    initial begin
        total = 0;
        bad   = 0;
        rr_seq[0] = 5'b00001;
        rr_seq[1] = 5'b00010;
        rr_seq[2] = 5'b10000;
        rr_seq[3] = 5'b00001;
        do_reset();
        nxt();

        for (int i = 0; i < 10; i++) begin
            expect_out("rst_idle", 5'b0, 5'b0, 1'b0, 3'd4);
            chk("rst_idle.err", 32'(bus.credit_err_o), 32'd0);
            nxt();
        end

        bus.req_i = 5'b00100; bus.flit_vld_i = 5'b00100;
        expect_out("pkt3.idle", 5'b0, 5'b0, 1'b0, 3'd4);
        nxt();
        bus.req_i = '0;
        expect_out("pkt3.f0", 5'b00100, 5'b00100, 1'b1, 3'd4);
        nxt();
        expect_out("pkt3.f1", 5'b00100, 5'b00100, 1'b1, 3'd3);
        nxt();
        bus.flit_is_tail_i = 5'b00100;
        expect_out("pkt3.f2", 5'b00100, 5'b00100, 1'b1, 3'd2);
        nxt();
        bus.flit_is_tail_i = '0; bus.flit_vld_i = '0;
        expect_out("pkt3.done", 5'b0, 5'b0, 1'b0, 3'd1);

        do_reset();
        bus.req_i = 5'b10011; bus.flit_vld_i = 5'b11111; bus.flit_is_tail_i = 5'b11111;
        for (int i = 0; i < 4; i++) begin
            bus.credit_ret_i = 1'b0;
            expect_out("rr.idle", 5'b0, 5'b0, 1'b0, 3'd4);
            nxt();
            bus.credit_ret_i = 1'b1;
            expect_out("rr.lock", rr_seq[i], rr_seq[i], 1'b1, 3'd4);
            nxt();
        end
        bus.credit_ret_i = 1'b0; bus.req_i = '0;
        expect_out("rr.end", 5'b0, 5'b0, 1'b0, 3'd4);
        chk("rr.err", 32'(bus.credit_err_o), 32'd0);

        do_reset();
        bus.req_i = 5'b00010; bus.flit_vld_i = 5'b00010;
        expect_out("cred.idle", 5'b0, 5'b0, 1'b0, 3'd4);
        nxt();
        bus.req_i = '0;
        for (int i = 0; i < 4; i++) begin
            expect_out("cred.burst", 5'b00010, 5'b00010, 1'b1, 3'(4 - i));
            nxt();
        end
        expect_out("cred.stall0", 5'b00010, 5'b0, 1'b0, 3'd0);
        nxt();
        bus.credit_ret_i = 1'b1;
        expect_out("cred.nobypass", 5'b00010, 5'b0, 1'b0, 3'd0);
        nxt();
        bus.credit_ret_i = 1'b0;
        expect_out("cred.one", 5'b00010, 5'b00010, 1'b1, 3'd1);
        nxt();
        expect_out("cred.stall1", 5'b00010, 5'b0, 1'b0, 3'd0);
        bus.credit_ret_i = 1'b1;
        nxt();
        bus.flit_is_tail_i = 5'b00010;
        expect_out("cred.tail", 5'b00010, 5'b00010, 1'b1, 3'd1);
        nxt();
        bus.credit_ret_i = 1'b0; bus.flit_is_tail_i = '0; bus.flit_vld_i = '0;
        expect_out("cred.same", 5'b0, 5'b0, 1'b0, 3'd1);

        do_reset();
        bus.req_i = 5'b00010; bus.flit_vld_i = 5'b00010;
        expect_out("lock.idle", 5'b0, 5'b0, 1'b0, 3'd4);
        nxt();
        bus.req_i = 5'b00001; bus.flit_vld_i = 5'b00011;
        expect_out("lock.f0", 5'b00010, 5'b00010, 1'b1, 3'd4);
        nxt();
        bus.flit_vld_i = 5'b00001;
        expect_out("lock.stall", 5'b00010, 5'b0, 1'b0, 3'd3);
        nxt();
        bus.flit_vld_i = 5'b00011;
        expect_out("lock.f1", 5'b00010, 5'b00010, 1'b1, 3'd3);
        nxt();
        bus.flit_is_tail_i = 5'b00010;
        expect_out("lock.tail", 5'b00010, 5'b00010, 1'b1, 3'd2);
        nxt();
        bus.flit_is_tail_i = '0;
        expect_out("lock.gap", 5'b0, 5'b0, 1'b0, 3'd1);
        nxt();
        expect_out("lock.next", 5'b00001, 5'b00001, 1'b1, 3'd1);

        do_reset();
        bus.credit_ret_i = 1'b1;
        expect_out("err.pulse", 5'b0, 5'b0, 1'b0, 3'd4);
        chk("err.before", 32'(bus.credit_err_o), 32'd0);
        nxt();
        bus.credit_ret_i = 1'b0;
        expect_out("err.sat", 5'b0, 5'b0, 1'b0, 3'd4);
        chk("err.set", 32'(bus.credit_err_o), 32'd1);
        nxt();
        bus.req_i = 5'b00100; bus.flit_vld_i = 5'b00100;
        nxt();
        bus.req_i = '0;
        expect_out("err.xfer", 5'b00100, 5'b00100, 1'b1, 3'd4);
        chk("err.sticky", 32'(bus.credit_err_o), 32'd1);
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0; bus.req_i = 5'b11111; bus.flit_vld_i = '0;
        expect_out("midrst", 5'b0, 5'b0, 1'b0, 3'd4);
        chk("midrst.err", 32'(bus.credit_err_o), 32'd0);
        nxt();
        expect_out("midrst.grant", 5'b00001, 5'b0, 1'b0, 3'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
